spart_tx: RTL and testbench
===========================

SPART_TX -- requirements
Module: spart_tx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, giving the number of enable pulses per serial bit time.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port enable, input, 1, a one-clk pulse from the baud generator at OVERSAMPLE x baud rate.
REQ-005 SHALL have port databus_tx, input, 8, the transmit byte from the databus stage.
REQ-006 SHALL have port tx_load, input, 1, a one-clk write strobe (iorw=0, ioaddr=2'b00), decoded upstream.
REQ-007 SHALL have port tbr, output, 1, transmit buffer ready: high when the holding register is empty.
REQ-008 SHALL have port txd, output, 1, the serial line, registered, idle high.

Function
REQ-009 SHALL be double-buffered: an 8-bit holding register (hold, hold_full) feeds an 8-bit shift register.
REQ-010 SHALL frame each byte as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1): 10 bit times, 10*OVERSAMPLE enable pulses.
REQ-011 SHALL use FSM states IDLE, START, DATA, STOP; txd=1 in IDLE and STOP, 0 in START, shift[0] in DATA.
REQ-012 SHALL keep a tick counter of width clog2(OVERSAMPLE), incremented only on enable; a bit time ends on the enable pulse that takes it to OVERSAMPLE-1, after which it wraps to 0.
REQ-013 SHALL keep a 3-bit bit counter in DATA; at the end of each bit time, shift right by one; after bit 7, go to STOP.
REQ-014 SHALL transition START->DATA at the end of the start bit time, STOP->IDLE at the end of the stop bit time.
REQ-015 SHALL, in IDLE with hold_full=1, copy hold into shift, clear hold_full, clear the tick counter, and enter START on the same edge; txd goes to 0 on that edge.
REQ-016 SHALL accept tx_load when hold_full=0, or when a REQ-015 transfer occurs on the same edge; hold<=databus_tx and hold_full<=1.
REQ-017 SHALL ignore tx_load when hold_full=1 and no transfer occurs on that edge; hold is unchanged and the byte is dropped.
REQ-018 SHALL drive tbr = ~hold_full; it is registered and falls on the edge that accepts a load.
REQ-019 SHALL ignore enable in IDLE; the tick counter is held at 0 there.
REQ-020 SHALL, for a load into an empty hold while IDLE: load edge N, transfer edge N+1, txd=0 from N+1, tbr=1 again from N+1.
REQ-021 SHALL, for back-to-back frames, insert exactly one clk of IDLE between the STOP end and the next START.
REQ-022 SHALL NOT stretch or shorten bit times when enable pulses are missing; a bit time is defined purely by the count of enable pulses.

Reset
REQ-023 SHALL, when rst_n=0 at a clk edge, force state=IDLE, txd=1, tbr=1, hold_full=0, hold=8'h00, shift=8'h00, and both counters to 0.
REQ-024 SHALL abort any frame in progress on reset mid-frame; txd returns to 1 on that edge and the pending hold byte is discarded.
REQ-025 SHALL ignore tx_load and enable while rst_n=0.

Verification
REQ-026 SHALL cover single byte: load 8'hA5 in IDLE, OVERSAMPLE=16, enable every 4 clk -> txd = 0,1,0,1,0,0,1,0,1,1, each held 16 enables; tbr=0 for exactly 1 clk.
REQ-027 SHALL cover back-to-back: load 8'h55 and then 8'h0F during the first frame -> tbr low from the second load until the frame ends; exactly one idle clk between frames; second frame correct.
REQ-028 SHALL cover overflow: load 8'h11, then 8'h22 (accepted into hold), then 8'h33 while tbr=0 -> transmitted 8'h11, 8'h22 only; 8'h33 never appears on txd.
REQ-029 SHALL cover the simultaneous case: tx_load of 8'h77 on the exact REQ-015 transfer edge -> accepted, tbr stays 0, 8'h77 sent as the next frame.
REQ-030 SHALL cover reset mid-frame: rst_n=0 for 1 clk during data bit 3 of 8'hFF with hold full -> txd=1, tbr=1, no further frame emitted.
REQ-031 SHALL cover enable gating: enable held low for 100 clk in the middle of bit 5 -> txd level unchanged; bit 5 completes after its remaining enable pulses arrive.

Source files
------------

// File: rtl/spart_tx.sv
// SPART transmitter: double-buffered 8N1 serializer driven by an oversampled baud enable.
// A holding register decouples the bus from the shift register so a second byte can wait during a frame.
module spart_tx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] databus_tx,
   input  logic       tx_load,
   output logic       tbr,
   output logic       txd
);

   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_n;
   logic [TW-1:0]   tick, tick_n, tick_adv;
   logic [2:0]      bit_cnt, bit_n;
   logic [7:0]      shift, shift_n;
   logic [7:0]      hold, hold_n;
   logic            hold_full, hold_full_n;
   logic            txd_n;
   logic            bit_end;
   logic            transfer;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         tick      <= '0;
         bit_cnt   <= '0;
         shift     <= 8'h00;
         hold      <= 8'h00;
         hold_full <= 1'b0;
         txd       <= 1'b1;
      end else begin
         state     <= state_n;
         tick      <= tick_n;
         bit_cnt   <= bit_n;
         shift     <= shift_n;
         hold      <= hold_n;
         hold_full <= hold_full_n;
         txd       <= txd_n;
      end
   end

   always_comb begin
      state_n     = state;
      tick_n      = tick;
      bit_n       = bit_cnt;
      shift_n     = shift;
      hold_n      = hold;
      hold_full_n = hold_full;
      transfer    = 1'b0;
      txd_n       = 1'b1;
      // A bit time is purely a count of enable pulses; missing pulses just pause it.
      bit_end     = enable && (tick == TICK_MAX);
      tick_adv    = enable ? (bit_end ? '0 : tick + TW'(1)) : tick;

      case (state)
         IDLE: begin
            tick_n = '0;
            bit_n  = '0;
            if (hold_full) begin
               transfer = 1'b1;
               shift_n  = hold;
               state_n  = START;
            end
         end
         START: begin
            tick_n = tick_adv;
            if (bit_end) begin
               state_n = DATA;
               bit_n   = '0;
            end
         end
         DATA: begin
            tick_n = tick_adv;
            if (bit_end) begin
               shift_n = {1'b0, shift[7:1]};
               if (bit_cnt == 3'd7) begin
                  state_n = STOP;
                  bit_n   = '0;
               end else begin
                  bit_n = bit_cnt + 3'd1;
               end
            end
         end
         STOP: begin
            tick_n = tick_adv;
            if (bit_end) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // The transfer edge frees the holding register, so a load on that same edge is kept.
      if (transfer) begin
         hold_full_n = tx_load;
         if (tx_load) hold_n = databus_tx;
      end else if (tx_load && !hold_full) begin
         hold_n      = databus_tx;
         hold_full_n = 1'b1;
      end

      case (state_n)
         START:   txd_n = 1'b0;
         DATA:    txd_n = shift_n[0];
         default: txd_n = 1'b1;
      endcase
   end

   assign tbr = ~hold_full;

endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx: frames are checked bit by bit against {stop, byte, start},
// sampling txd on the negative edge just before every enable pulse.
module tb_spart_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       tx_load = 1'b0;
   logic [7:0] databus_tx = 8'h00;
   logic       tbr;
   logic       txd;

   int n_tests = 0;
   int n_fail  = 0;

   spart_tx #(.OVERSAMPLE(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .databus_tx (databus_tx),
      .tx_load    (tx_load),
      .tbr        (tbr),
      .txd        (txd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive inputs for one clock, return at the following negedge with strobes cleared.
   task automatic cyc(input logic en, input logic ld, input logic [7:0] d);
      enable     = en;
      tx_load    = ld;
      databus_tx = d;
      @(negedge clk);
      enable  = 1'b0;
      tx_load = 1'b0;
   endtask

   // Issue n_en enable pulses (one every 4 clk), optional loads and one 100-clk enable gap.
   task automatic run_frame(input string tag, input logic [7:0] b, input int n_en,
                            input int ld0_at, input logic [7:0] ld0_d,
                            input int ld1_at, input logic [7:0] ld1_d,
                            input int gap_at);
      logic [9:0]  frame;
      logic [15:0] samples;
      logic [15:0] gap_bad;
      frame   = {1'b1, b, 1'b0};
      samples = '0;
      for (int k = 0; k < n_en; k++) begin
         for (int j = 0; j < 3; j++) begin
            if (j == 0 && k == ld0_at)      cyc(1'b0, 1'b1, ld0_d);
            else if (j == 0 && k == ld1_at) cyc(1'b0, 1'b1, ld1_d);
            else                            cyc(1'b0, 1'b0, 8'h00);
         end
         if (k == gap_at) begin
            gap_bad = '0;
            for (int g = 0; g < 100; g++) begin
               if (txd !== frame[k/16]) gap_bad++;
               cyc(1'b0, 1'b0, 8'h00);
            end
            chk({tag, " gap"}, gap_bad, 16'h0000);
         end
         samples[k%16] = txd;
         if (k % 16 == 15)
            chk($sformatf("%s bit%0d", tag, k/16), samples, {16{frame[k/16]}});
         cyc(1'b1, 1'b0, 8'h00);
      end
   endtask

   initial begin
      logic [15:0] bad;

      // Reset with strobes active: they must be ignored.
      rst_n = 1'b0; enable = 1'b1; tx_load = 1'b1; databus_tx = 8'h99;
      repeat (3) @(negedge clk);
      chk("reset txd", txd, 1'b1);
      chk("reset tbr", tbr, 1'b1);
      rst_n = 1'b1; enable = 1'b0; tx_load = 1'b0;
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      chk("post reset txd", txd, 1'b1);
      chk("post reset tbr", tbr, 1'b1);

      // Single byte: tbr low exactly one clk, start bit on the transfer edge.
      cyc(1'b0, 1'b1, 8'hA5);
      chk("a5 load tbr", tbr, 1'b0);
      chk("a5 load txd", txd, 1'b1);
      cyc(1'b0, 1'b0, 8'h00);
      chk("a5 xfer tbr", tbr, 1'b1);
      chk("a5 xfer txd", txd, 1'b0);
      run_frame("a5", 8'hA5, 160, -1, 8'h00, -1, 8'h00, -1);
      chk("a5 end txd", txd, 1'b1);
      chk("a5 end tbr", tbr, 1'b1);
      cyc(1'b0, 1'b0, 8'h00);
      chk("a5 stays idle", txd, 1'b1);

      // Back-to-back: second byte waits in hold, one idle clk between frames.
      cyc(1'b0, 1'b1, 8'h55);
      cyc(1'b0, 1'b0, 8'h00);
      chk("b2b first start", txd, 1'b0);
      run_frame("b2b55", 8'h55, 160, 20, 8'h0F, -1, 8'h00, -1);
      chk("b2b tbr held", tbr, 1'b0);
      chk("b2b idle clk", txd, 1'b1);
      cyc(1'b0, 1'b0, 8'h00);
      chk("b2b second start", txd, 1'b0);
      chk("b2b tbr release", tbr, 1'b1);
      run_frame("b2b0f", 8'h0F, 160, -1, 8'h00, -1, 8'h00, -1);
      chk("b2b end txd", txd, 1'b1);

      // Overflow: 8'h33 arrives with hold full and is dropped.
      cyc(1'b0, 1'b1, 8'h11);
      cyc(1'b0, 1'b0, 8'h00);
      run_frame("ov11", 8'h11, 160, 10, 8'h22, 50, 8'h33, -1);
      chk("ov tbr held", tbr, 1'b0);
      cyc(1'b0, 1'b0, 8'h00);
      chk("ov second start", txd, 1'b0);
      chk("ov tbr release", tbr, 1'b1);
      run_frame("ov22", 8'h22, 160, -1, 8'h00, -1, 8'h00, -1);
      chk("ov end tbr", tbr, 1'b1);
      bad = '0;
      for (int i = 0; i < 160; i++) begin
         if (txd !== 1'b1) bad++;
         cyc(i % 4 == 3, 1'b0, 8'h00);
      end
      chk("ov no third frame", bad, 16'h0000);

      // Load on the exact transfer edge is accepted.
      cyc(1'b0, 1'b1, 8'h3C);
      cyc(1'b0, 1'b1, 8'h77);
      chk("sim xfer txd", txd, 1'b0);
      chk("sim tbr stays low", tbr, 1'b0);
      run_frame("sim3c", 8'h3C, 160, -1, 8'h00, -1, 8'h00, -1);
      chk("sim tbr held", tbr, 1'b0);
      cyc(1'b0, 1'b0, 8'h00);
      chk("sim second start", txd, 1'b0);
      chk("sim tbr release", tbr, 1'b1);
      run_frame("sim77", 8'h77, 160, -1, 8'h00, -1, 8'h00, -1);
      chk("sim end txd", txd, 1'b1);

      // Enable gating in the middle of data bit 5 (frame bit 6).
      cyc(1'b0, 1'b1, 8'hC3);
      cyc(1'b0, 1'b0, 8'h00);
      run_frame("gate", 8'hC3, 160, -1, 8'h00, -1, 8'h00, 104);
      chk("gate end txd", txd, 1'b1);
      chk("gate end tbr", tbr, 1'b1);

      // Reset during data bit 3 of 8'hFF with a byte pending in hold.
      cyc(1'b0, 1'b1, 8'hFF);
      cyc(1'b0, 1'b0, 8'h00);
      run_frame("rst", 8'hFF, 70, 5, 8'hAA, -1, 8'h00, -1);
      chk("rst pre tbr", tbr, 1'b0);
      chk("rst pre txd", txd, 1'b1);
      rst_n = 1'b0;
      cyc(1'b1, 1'b1, 8'h44);
      rst_n = 1'b1;
      chk("rst txd", txd, 1'b1);
      chk("rst tbr", tbr, 1'b1);
      bad = '0;
      for (int i = 0; i < 640; i++) begin
         if (txd !== 1'b1 || tbr !== 1'b1) bad++;
         cyc(i % 4 == 3, 1'b0, 8'h00);
      end
      chk("rst no frame", bad, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
